// File: rtl/exec_stage_if.sv
// ---------------------------------------------------------------------------
// exec_stage_if
// Bundles every signal between the execute stage and its neighbours (the
// decode/fetch side that issues instructions and the register file).
//
//   in_valid/in_ready   : instruction handshake into the stage
//   icode/ifun/rA/rB/valC : decoded instruction fields
//   srcA/srcB           : register file read addresses (from the stage)
//   valA/valB           : register file read data (into the stage)
//   dstE/valE           : register file write port E (from the stage)
//   cc                  : condition codes {ZF,SF,OF}
//   halted/err          : stop status
//   retired             : executed-instruction counter
//
// Modports:
//   master : environment side (issues instructions, serves reads/writes)
//   slave  : the execute stage itself
// ---------------------------------------------------------------------------
interface exec_stage_if #(
    parameter int W     = 32,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       icode;
    logic [3:0]       ifun;
    logic [3:0]       rA;
    logic [3:0]       rB;
    logic [15:0]      valC;
    logic [3:0]       srcA;
    logic [3:0]       srcB;
    logic [W-1:0]     valA;
    logic [W-1:0]     valB;
    logic [3:0]       dstE;
    logic [W-1:0]     valE;
    logic [2:0]       cc;
    logic             halted;
    logic             err;
    logic [CNT_W-1:0] retired;

    modport master (
        output in_valid, icode, ifun, rA, rB, valC, valA, valB,
        input  in_ready, srcA, srcB, dstE, valE, cc, halted, err, retired
    );

    modport slave (
        input  in_valid, icode, ifun, rA, rB, valC, valA, valB,
        output in_ready, srcA, srcB, dstE, valE, cc, halted, err, retired
    );
endinterface

// File: rtl/exec_stage.sv
// ---------------------------------------------------------------------------
// exec_stage
// Execute/writeback stage. An accepted instruction is captured in D, its
// operands are read from the register file (with forwarding from E), and
// the result is registered into E, which drives the register file write
// port. Holds condition codes, counts retired instructions and stops on a
// halt or an illegal instruction.
//
// Ports:
//   clock : single clock, rising edge
//   reset : synchronous, active-low
//   bus   : exec_stage_if.slave (handshake, decoded fields, register file
//           read/write ports, cc, halted, err, retired)
// ---------------------------------------------------------------------------
module exec_stage #(
    parameter int W     = 32,
    parameter int CNT_W = 16
) (
    input  logic         clock,
    input  logic         reset,
    exec_stage_if.slave  bus
);
    localparam logic [3:0] REG_NONE = 4'hF;

    typedef enum logic {S_RUN, S_HALT} state_t;

    state_t r_state;
    state_t w_state_nxt;

    // D register
    logic             r_d_vld;
    logic [3:0]       r_d_icode;
    logic [3:0]       r_d_ifun;
    logic [3:0]       r_d_ra;
    logic [3:0]       r_d_rb;
    logic [15:0]      r_d_valc;

    // E register and architectural status
    logic [3:0]       r_dste;
    logic [W-1:0]     r_vale;
    logic [2:0]       r_cc;
    logic             r_halted;
    logic             r_err;
    logic [CNT_W-1:0] r_retired;

    logic [3:0]       w_srca;
    logic [3:0]       w_srcb;
    logic [W-1:0]     w_rda;
    logic [W-1:0]     w_rdb;
    logic [W-1:0]     w_opa;
    logic [W-1:0]     w_opb;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_legal;
    logic             w_illegal;
    logic             w_halt_ins;
    logic             w_upd_vale;
    logic [3:0]       w_dst_nxt;
    logic [W-1:0]     w_res;
    logic [2:0]       w_cc_nxt;
    logic [W:0]       w_alu;

    // Returns {OF, result} for OPl; result is rB op rA, modulo 2^W.
    function automatic logic [W:0] alu_op(
        input logic [3:0]   fn,
        input logic [W-1:0] a,
        input logic [W-1:0] b
    );
        logic [W-1:0] r;
        logic         of;
        r  = '0;
        of = 1'b0;
        case (fn)
            4'd0: begin
                r  = b + a;
                of = (a[W-1] == b[W-1]) && (r[W-1] != b[W-1]);
            end
            4'd1: begin
                r  = b - a;
                of = (b[W-1] != a[W-1]) && (r[W-1] != b[W-1]);
            end
            4'd2:    r = b & a;
            4'd3:    r = b ^ a;
            default: r = '0;
        endcase
        return {of, r};
    endfunction

    // Operand read: index F reads as zero regardless of the register file.
    assign w_srca = r_d_vld ? r_d_ra : REG_NONE;
    assign w_srcb = r_d_vld ? r_d_rb : REG_NONE;
    assign w_rda  = (w_srca == REG_NONE) ? '0 : bus.valA;
    assign w_rdb  = (w_srcb == REG_NONE) ? '0 : bus.valB;

    // E is committed to the register file at the same edge D executes, so a
    // value still sitting in E has to bypass the (stale) register file read.
    assign w_opa = ((r_dste != REG_NONE) && (r_dste == w_srca)) ? r_vale : w_rda;
    assign w_opb = ((r_dste != REG_NONE) && (r_dste == w_srcb)) ? r_vale : w_rdb;

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = (r_state == S_RUN);
        w_legal     = 1'b0;
        w_illegal   = 1'b0;
        w_halt_ins  = 1'b0;
        w_upd_vale  = 1'b0;
        w_dst_nxt   = REG_NONE;
        w_res       = '0;
        w_cc_nxt    = r_cc;
        w_alu       = '0;

        if (r_d_vld) begin
            case (r_d_icode)
                4'h0: w_legal = 1'b1;
                4'h1: begin
                    if (r_d_ifun == 4'h0) begin
                        w_legal    = 1'b1;
                        w_dst_nxt  = r_d_rb;
                        w_res      = W'(r_d_valc);
                        w_upd_vale = 1'b1;
                    end else begin
                        w_illegal = 1'b1;
                    end
                end
                4'h2: begin
                    if (r_d_ifun <= 4'd3) begin
                        w_legal    = 1'b1;
                        w_alu      = alu_op(r_d_ifun, w_opa, w_opb);
                        w_res      = w_alu[W-1:0];
                        w_dst_nxt  = r_d_rb;
                        w_upd_vale = 1'b1;
                        w_cc_nxt   = {(w_alu[W-1:0] == '0), w_alu[W-1], w_alu[W]};
                    end else begin
                        w_illegal = 1'b1;
                    end
                end
                4'hF: begin
                    if (r_d_ifun == 4'h0) begin
                        w_legal    = 1'b1;
                        w_halt_ins = 1'b1;
                    end else begin
                        w_illegal = 1'b1;
                    end
                end
                default: w_illegal = 1'b1;
            endcase
        end

        if (w_halt_ins || w_illegal) begin
            w_state_nxt = S_HALT;
        end
    end

    // An instruction arriving on the edge that enters HALT is dropped so D
    // is empty from the first halted cycle on.
    assign w_accept = bus.in_valid && w_in_ready && (w_state_nxt == S_RUN);

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Stage D: capture
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_d_vld <= 1'b0;
        end else begin
            r_d_vld <= w_accept;
        end
    end

    always_ff @(posedge clock) begin
        if (w_accept) begin
            r_d_icode <= bus.icode;
            r_d_ifun  <= bus.ifun;
            r_d_ra    <= bus.rA;
            r_d_rb    <= bus.rB;
            r_d_valc  <= bus.valC;
        end
    end

    // Stage E: result / writeback
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_dste    <= REG_NONE;
            r_vale    <= '0;
            r_cc      <= 3'b100;
            r_halted  <= 1'b0;
            r_err     <= 1'b0;
            r_retired <= '0;
        end else begin
            r_dste <= w_dst_nxt;
            if (w_upd_vale) begin
                r_vale <= w_res;
            end
            r_cc <= w_cc_nxt;
            if (w_legal) begin
                r_retired <= r_retired + CNT_W'(1);
            end
            if (w_halt_ins || w_illegal) begin
                r_halted <= 1'b1;
            end
            if (w_illegal) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus.in_ready = w_in_ready;
    assign bus.srcA     = w_srca;
    assign bus.srcB     = w_srcb;
    assign bus.dstE     = r_dste;
    assign bus.valE     = r_vale;
    assign bus.cc       = r_cc;
    assign bus.halted   = r_halted;
    assign bus.err      = r_err;
    assign bus.retired  = r_retired;
endmodule

// File: tb/tb_exec_stage.sv
// ---------------------------------------------------------------------------
// tb_exec_stage
// Testbench for exec_stage: owns a register file wired to the stage's read
// and write ports, applies a table of directed instructions, a few
// multi-cycle sequences (illegal, halt, reset mid-flight) and a random
// instruction stream compared against an architectural model.
// ---------------------------------------------------------------------------
module tb_exec_stage;
    localparam int W     = 32;
    localparam int CNT_W = 16;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    exec_stage_if #(.W(W), .CNT_W(CNT_W)) bus();

    exec_stage #(.W(W), .CNT_W(CNT_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Register file: combinational read, write at the edge from dstE/valE.
    logic [W-1:0] rf [16];
    logic         pre_en;
    logic         pre_clr;
    logic [3:0]   pre_idx;
    logic [W-1:0] pre_val;

    always @(posedge clock) begin
        if (pre_clr) begin
            for (int i = 0; i < 16; i++) rf[i] <= '0;
        end else if (pre_en) begin
            rf[pre_idx] <= pre_val;
        end else if (bus.dstE != 4'hF) begin
            rf[bus.dstE] <= bus.valE;
        end
    end

    // Index F must read as zero inside the stage, so feed garbage there.
    assign bus.valA = (bus.srcA == 4'hF) ? 32'hDEADBEEF : rf[bus.srcA];
    assign bus.valB = (bus.srcB == 4'hF) ? 32'hCAFEF00D : rf[bus.srcB];

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] w);
        bus.in_valid = v;
        bus.icode    = w[31:28];
        bus.ifun     = w[27:24];
        bus.rA       = w[23:20];
        bus.rB       = w[19:16];
        bus.valC     = w[15:0];
    endtask

    task automatic rf_set(input logic [3:0] idx, input logic [W-1:0] val);
        pre_idx = idx;
        pre_val = val;
        pre_en  = 1'b1;
        tick();
        pre_en  = 1'b0;
    endtask

    // Directed vectors: word issued back-to-back, expected E contents after
    // the instruction executes.
    typedef struct {
        logic [31:0]      word;
        logic [3:0]       dst;
        logic [W-1:0]     val;
        logic [2:0]       cc;
        logic [CNT_W-1:0] ret;
        logic             chk_val;
    } vec_t;

    localparam int NV = 8;
    vec_t vec [NV];

    task automatic check_vec(input int i);
        chk($sformatf("vec%0d_dstE", i), 64'(bus.dstE), 64'(vec[i].dst));
        if (vec[i].chk_val) chk($sformatf("vec%0d_valE", i), 64'(bus.valE), 64'(vec[i].val));
        chk($sformatf("vec%0d_cc", i), 64'(bus.cc), 64'(vec[i].cc));
        chk($sformatf("vec%0d_retired", i), 64'(bus.retired), 64'(vec[i].ret));
    endtask

    // Architectural model: instructions executed in program order.
    logic [W-1:0]     mreg [16];
    logic [2:0]       mcc;
    logic [CNT_W-1:0] mret;

    task automatic model_exec(input logic [31:0] w, output logic [3:0] d, output logic [W-1:0] v);
        logic [3:0]   ic, fn, ra, rb;
        logic [W-1:0] a, b, r;
        longint       s;
        logic         of;
        ic = w[31:28]; fn = w[27:24]; ra = w[23:20]; rb = w[19:16];
        a  = (ra == 4'hF) ? '0 : mreg[ra];
        b  = (rb == 4'hF) ? '0 : mreg[rb];
        d  = 4'hF;
        v  = '0;
        r  = '0;
        of = 1'b0;
        mret = mret + 1'b1;
        if (ic == 4'h1) begin
            d = rb;
            v = {16'h0, w[15:0]};
        end else if (ic == 4'h2) begin
            s = 0;
            case (fn)
                4'd0: begin r = b + a; s = longint'($signed(b)) + longint'($signed(a)); end
                4'd1: begin r = b - a; s = longint'($signed(b)) - longint'($signed(a)); end
                4'd2: r = b & a;
                default: r = b ^ a;
            endcase
            if (fn <= 4'd1) of = (s > SMAX) || (s < SMIN);
            mcc = {(r == 0), r[W-1], of};
            d = rb;
            v = r;
        end
        if (d != 4'hF) mreg[d] = v;
    endtask

    function automatic logic [3:0] pick_reg();
        return ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 7));
    endfunction

    function automatic logic [31:0] rand_word();
        int k;
        k = $urandom_range(0, 2);
        if (k == 0) return {4'h0, 4'($urandom_range(0, 15)), pick_reg(), pick_reg(), 16'($urandom)};
        if (k == 1) return {4'h1, 4'h0, 4'hF, pick_reg(), 16'($urandom)};
        return {4'h2, 4'($urandom_range(0, 3)), pick_reg(), pick_reg(), 16'($urandom)};
    endfunction

    initial begin
        logic             v, acc, p_acc;
        logic [31:0]      w;
        logic [3:0]       n_dst, p_dst;
        logic [W-1:0]     n_val, p_val;
        logic [2:0]       n_cc, p_cc;
        logic [CNT_W-1:0] n_ret, p_ret;

        vec[0] = '{32'h10F00080, 4'h0, 32'h00000080, 3'b100, 16'd1, 1'b1};
        vec[1] = '{32'h10F10081, 4'h1, 32'h00000081, 3'b100, 16'd2, 1'b1};
        vec[2] = '{32'h20010000, 4'h1, 32'h00000101, 3'b000, 16'd3, 1'b1};
        vec[3] = '{32'h20320000, 4'h2, 32'h80000000, 3'b011, 16'd4, 1'b1};
        vec[4] = '{32'h21540000, 4'h4, 32'h00000000, 3'b100, 16'd5, 1'b1};
        vec[5] = '{32'h23450000, 4'h5, 32'h00000005, 3'b000, 16'd6, 1'b1};
        vec[6] = '{32'h00000000, 4'hF, 32'h00000000, 3'b000, 16'd7, 1'b0};
        vec[7] = '{32'h10F6FFFF, 4'h6, 32'h0000FFFF, 3'b000, 16'd8, 1'b1};

        reset = 1'b0; pre_en = 1'b0; pre_clr = 1'b0; pre_idx = '0; pre_val = '0;
        drive(1'b0, 32'h0);
        tick(); tick();

        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_dstE", 64'(bus.dstE), 64'hF);
        chk("rst_valE", 64'(bus.valE), 64'd0);
        chk("rst_cc", 64'(bus.cc), 64'b100);
        chk("rst_halted", 64'(bus.halted), 64'd0);
        chk("rst_err", 64'(bus.err), 64'd0);
        chk("rst_retired", 64'(bus.retired), 64'd0);
        chk("rst_srcA", 64'(bus.srcA), 64'hF);

        pre_clr = 1'b1; tick(); pre_clr = 1'b0;
        rf_set(4'd2, 32'h7FFFFFFF);
        rf_set(4'd3, 32'h00000001);
        rf_set(4'd4, 32'h00000005);
        rf_set(4'd5, 32'h00000005);
        reset = 1'b1;

        // Directed table, issued back-to-back
        for (int i = 0; i < NV; i++) begin
            drive(1'b1, vec[i].word);
            tick();
            if (i > 0) check_vec(i - 1);
        end
        drive(1'b0, 32'h0);
        tick();
        check_vec(NV - 1);
        tick();
        chk("rf_r1", 64'(rf[1]), 64'h101);
        chk("rf_r2", 64'(rf[2]), 64'h80000000);
        chk("rf_r6", 64'(rf[6]), 64'hFFFF);

        // Illegal instruction followed by a held-valid irmovl to r6
        drive(1'b1, 32'h50000000);
        tick();
        drive(1'b1, 32'h10F60086);
        tick();
        chk("ill_halted", 64'(bus.halted), 64'd1);
        chk("ill_err", 64'(bus.err), 64'd1);
        chk("ill_in_ready", 64'(bus.in_ready), 64'd0);
        chk("ill_dstE", 64'(bus.dstE), 64'hF);
        chk("ill_retired", 64'(bus.retired), 64'd8);
        tick(); tick(); tick();
        chk("ill_hold_dstE", 64'(bus.dstE), 64'hF);
        chk("ill_hold_retired", 64'(bus.retired), 64'd8);
        chk("ill_hold_in_ready", 64'(bus.in_ready), 64'd0);
        chk("ill_no_r6_write", 64'(rf[6]), 64'hFFFF);

        drive(1'b0, 32'h0);
        reset = 1'b0; tick(); reset = 1'b1;
        chk("rel_halted", 64'(bus.halted), 64'd0);
        chk("rel_err", 64'(bus.err), 64'd0);
        chk("rel_retired", 64'(bus.retired), 64'd0);
        chk("rel_in_ready", 64'(bus.in_ready), 64'd1);

        // Halt instruction
        drive(1'b1, 32'hF0000000);
        tick();
        drive(1'b0, 32'h0);
        tick();
        chk("halt_halted", 64'(bus.halted), 64'd1);
        chk("halt_err", 64'(bus.err), 64'd0);
        chk("halt_retired", 64'(bus.retired), 64'd1);
        chk("halt_in_ready", 64'(bus.in_ready), 64'd0);
        chk("halt_dstE", 64'(bus.dstE), 64'hF);
        reset = 1'b0; tick(); reset = 1'b1;

        // Reset lands while one irmovl is in D and another is being accepted
        rf_set(4'd7, 32'h5555);
        drive(1'b1, 32'h10F70077);
        tick();
        drive(1'b1, 32'h10F80088);
        reset = 1'b0;
        tick();
        chk("rmid_dstE", 64'(bus.dstE), 64'hF);
        chk("rmid_retired", 64'(bus.retired), 64'd0);
        drive(1'b0, 32'h0);
        reset = 1'b1;
        tick();
        chk("rmid_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rmid_dstE_after", 64'(bus.dstE), 64'hF);
        tick();
        chk("rmid_r7", 64'(rf[7]), 64'h5555);
        chk("rmid_r8", 64'(rf[8]), 64'h0);

        // Random stream against the architectural model
        reset = 1'b0; tick(); reset = 1'b1;
        for (int i = 0; i < 16; i++) mreg[i] = rf[i];
        mcc = 3'b100;
        mret = '0;
        p_acc = 1'b0;
        p_dst = 4'hF; p_val = '0; p_cc = 3'b100; p_ret = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            v = ($urandom_range(0, 9) < 7);
            w = rand_word();
            drive(v, w);
            acc = v && bus.in_ready;
            n_dst = 4'hF; n_val = '0;
            if (acc) model_exec(w, n_dst, n_val);
            n_cc = mcc;
            n_ret = mret;
            tick();
            if (p_acc) begin
                chk("rnd_dstE", 64'(bus.dstE), 64'(p_dst));
                if (p_dst != 4'hF) chk("rnd_valE", 64'(bus.valE), 64'(p_val));
                chk("rnd_cc", 64'(bus.cc), 64'(p_cc));
                chk("rnd_retired", 64'(bus.retired), 64'(p_ret));
            end else begin
                chk("rnd_bubble_dstE", 64'(bus.dstE), 64'hF);
            end
            p_acc = acc; p_dst = n_dst; p_val = n_val; p_cc = n_cc; p_ret = n_ret;
        end
        drive(1'b0, 32'h0);
        tick();
        if (p_acc) begin
            chk("rnd_last_dstE", 64'(bus.dstE), 64'(p_dst));
            chk("rnd_last_cc", 64'(bus.cc), 64'(p_cc));
        end
        tick();
        for (int r = 0; r < 8; r++) begin
            chk($sformatf("rnd_rf_r%0d", r), 64'(rf[r]), 64'(mreg[r]));
        end
        chk("rnd_halted", 64'(bus.halted), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/exec_stage.md
Name: exec_stage

Overview:
- Execute/writeback stage directly downstream of the instruction fetch datapath.
- Consumes decoded fields icode/ifun/rA/rB/valC, reads operands from the register file, computes the result and drives the register file E write port (dstE/valE).
- Holds condition codes, detects illegal instructions and halts.
- Two internal registers: D (decode capture) and E (result/writeback), with forwarding from E into the operands of D.

Parameters:
- W, 32, datapath and register width.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low; reset==0 at a rising edge resets all state.
- in_valid  in  1  decoded instruction present on icode..valC.
- in_ready  out  1  stage accepts an instruction this cycle.
- icode  in  4  instruction code.
- ifun  in  4  function code.
- rA  in  4  source register; 4'hF = none.
- rB  in  4  source/destination register; 4'hF = none.
- valC  in  16  immediate.
- srcA  out  4  register file read address A (combinational from D).
- srcB  out  4  register file read address B (combinational from D).
- valA  in  W  register file data for srcA (combinational read).
- valB  in  W  register file data for srcB.
- dstE  out  4  write address; 4'hF = no write.
- valE  out  W  write data.
- cc  out  3  {ZF,SF,OF}.
- halted  out  1  stage stopped.
- err  out  1  stopped on an illegal instruction.
- retired  out  CNT_W  count of executed instructions.

Behaviour:
- Reset values:
  - D invalid.
  - dstE=4'hF, valE=0.
  - cc=3'b100.
  - halted=0, err=0, retired=0.
  - State RUN.
- in_ready = (state==RUN).
- Accept: in_valid & in_ready at an edge loads D and sets D valid. No accept leaves D invalid next cycle (bubble).
- srcA/srcB:
  - D.rA / D.rB when D is valid, else 4'hF.
  - An index of 4'hF reads as 0, independent of valA/valB.
- Forwarding:
  - opA = (dstE!=F && dstE==srcA) ? valE : valA. opB likewise.
  - Required because the register file commits dstE/valE at the same edge at which E is reloaded.
- Execute of valid D (one cycle), at the edge:
  - icode 0, any ifun (nop): dstE<=F; counts as retired.
  - icode 1, ifun 0 (irmovl): dstE<=D.rB; valE<={16'b0,valC}; cc unchanged.
  - icode 2 (OPl), ifun 0..3, result rB op rA:
    - ifun 0 add: opB+opA.
    - ifun 1 sub: opB-opA.
    - ifun 2 and.
    - ifun 3 xor.
    - dstE<=D.rB; valE<=result.
    - cc: ZF=(result==0); SF=result[W-1].
    - OF: add = signed overflow; sub = (opB sign != opA sign) && (result sign != opB sign); and/xor = 0.
    - Arithmetic is modulo 2^W.
  - icode F, ifun 0 (halt): dstE<=F; retired+1; state<=HALT; halted<=1; err stays 0.
  - Anything else: illegal. dstE<=F; retired unchanged; state<=HALT; halted<=1; err<=1.
- retired increments by 1 per legal executed instruction and wraps at 2^CNT_W.
- Invalid D: dstE<=F, valE holds, cc holds.
- Latency: instruction accepted at edge N → dstE/valE valid during cycle N+1→N+2 → register file written at edge N+2.
- Throughput: one instruction per cycle. Back-to-back dependent instructions need no stall (forwarding).
- HALT:
  - in_ready=0, inputs ignored.
  - D cleared at the transition edge; dstE returns to F the following edge.
  - Only reset leaves HALT.
- Reset mid-operation: reset wins over accept/execute at the same edge. The in-flight D instruction is discarded and any pending dstE is cancelled, so no register write is issued after reset.
- rB=F on irmovl/OPl: result computed, cc updated for OPl, no write (dstE=F).

Test Plan:
- Reset, then irmovl words 0x10F00080 and 0x10F10081 back-to-back → dstE=0,valE=0x80 then dstE=1,valE=0x81 on consecutive cycles; retired=2; cc=3'b100.
- After the above, 0x20010000 (add r0→r1) issued right after 0x10F10081 with a stale valB=0 → forwarding gives valE=0x101, dstE=1; ZF=0, SF=0, OF=0.
- r2=0x7FFFFFFF, r3=1: 0x20320000 → valE=0x80000000, cc={0,1,1}. r4=r5=5: 0x21540000 (sub) → valE=0, cc={1,0,0}.
- Illegal 0x5000_0000 followed by 0x10F60086 held valid → halted=1, err=1, in_ready=0, no write to r6, retired unchanged.
- Halt word 0xF0000000 → halted=1, err=0, retired increments.
- Assert reset low at the edge an irmovl is accepted → next cycle dstE=F, retired=0, in_ready=1 after release.
